// File: rtl/bar_width_sampler.sv
// bar_width_sampler: synchronises the raw scanner line, measures bar widths
// against the start-bar reference and emits 5-bit symbols with a one-hot
// position strobe for the downstream decoder.
module bar_width_sampler #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned QUIET = 64,
  parameter int unsigned MIN_N = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan,
  output logic [4:0] I,
  output logic [4:0] PG,
  output logic       err,
  output logic       code_done
);

  localparam int unsigned      Q_W     = $clog2(QUIET + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] N_MIN   = CNT_W'(MIN_N);
  localparam logic [CNT_W-1:0] N_MAX   = CNT_W'((1 << (CNT_W - 2)) - 1);
  localparam logic [Q_W-1:0]   Q_END   = Q_W'(QUIET);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_REF,
    S_GAP,
    S_BAR,
    S_DONE,
    S_ERR_Q
  } state_t;

  state_t           state;
  logic             s1, sc, sc_d;
  logic [CNT_W-1:0] cnt, run_c, n;
  logic [Q_W-1:0]   q, q_c;
  logic [2:0]       bitcnt;
  logic [2:0]       k;
  logic [3:0]       sh;
  logic             bit_c;
  logic [4:0]       word_c;

  // Run length of the current sc level (saturating) and quiet-zone count
  always_comb begin
    run_c  = '0;
    q_c    = '0;
    bit_c  = 1'b0;
    word_c = '0;
    if (sc != sc_d)
      run_c = CNT_W'(1);
    else if (cnt == CNT_MAX)
      run_c = cnt;
    else
      run_c = cnt + CNT_W'(1);
    if (sc)
      q_c = '0;
    else if (q == Q_END)
      q_c = q;
    else
      q_c = q + Q_W'(1);
    // cnt holds the length of the bar that just ended when sc first reads 0
    bit_c  = (cnt >= (n + (n >> 1)));
    word_c = {sh, bit_c};
  end

  // Two-flop synchroniser, edge history and the run/quiet counters
  always_ff @(posedge clock) begin
    if (reset) begin
      s1   <= 1'b0;
      sc   <= 1'b0;
      sc_d <= 1'b0;
      cnt  <= '0;
      q    <= '0;
    end else begin
      s1   <= scan;
      sc   <= s1;
      sc_d <= sc;
      cnt  <= run_c;
      q    <= q_c;
    end
  end

  // Decode FSM with registered symbol, strobe and pulse outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      n         <= '0;
      bitcnt    <= '0;
      k         <= '0;
      sh        <= '0;
      I         <= '0;
      PG        <= '0;
      err       <= 1'b0;
      code_done <= 1'b0;
    end else begin
      I         <= '0;
      PG        <= '0;
      err       <= 1'b0;
      code_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (q_c == Q_END) state <= S_ARMED;
        end
        S_ARMED: begin
          if (sc) state <= S_REF;
        end
        S_REF: begin
          if (!sc) begin
            if (cnt < N_MIN || cnt > N_MAX) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              n      <= cnt;
              bitcnt <= '0;
              k      <= '0;
              state  <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (sc)
            state <= S_BAR;
          else if (q_c == Q_END)
            state <= S_ERR_Q;
        end
        S_BAR: begin
          if (sc) begin
            // Overlong bar is flagged as soon as it passes 4N
            if (run_c > (n << 2)) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end
          end else if (cnt < (n >> 1)) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (bitcnt == 3'd4) begin
            I      <= word_c;
            PG     <= 5'b10000 >> k;
            k      <= k + 3'd1;
            bitcnt <= '0;
            state  <= (k == 3'd4) ? S_DONE : S_GAP;
          end else begin
            sh     <= {sh[2:0], bit_c};
            bitcnt <= bitcnt + 3'd1;
            state  <= S_GAP;
          end
        end
        S_DONE: begin
          if (sc) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (q_c == Q_END) begin
            code_done <= 1'b1;
            state     <= S_ARMED;
          end
        end
        S_ERR_Q: begin
          // Quiet zone already seen, so a bar here is a new start bar
          err   <= 1'b1;
          state <= sc ? S_REF : S_ARMED;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bar_width_sampler.md
# bar_width_sampler

Front-end stage of the bar-code reader. It takes the raw scanner line, synchronises it, and measures the width of every bar against a narrow-width reference taken from the start bar. It packs each group of five bars into a 5-bit symbol (wide = 1) and presents that symbol on `I` with a one-hot position strobe on `PG`. The downstream decoder (`Schematic`) consumes those two buses directly.

## Interface
- `CNT_W`, 8: width of the run-length counter; the counter saturates at 2^CNT_W-1.
- `QUIET`, 64: number of consecutive space cycles that counts as a quiet zone / end of code.
- `MIN_N`, 2: minimum legal start-bar width, in cycles.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `scan`  in  1: raw scanner line, 1 = dark bar; asynchronous to `clock`.
- `I`  out  5: symbol bits, first bar of the symbol in bit 4; valid only while `PG` != 0.
- `PG`  out  5: one-hot symbol position; symbol k (0..4) asserts `PG[4-k]` for one cycle.
- `err`  out  1: one-cycle pulse on any format violation.
- `code_done`  out  1: one-cycle pulse when the trailing quiet zone follows the 5th symbol.

## Operation
- **Input synchronisation:** `scan` passes through a 2-flop synchroniser to give `sc`. All rules below refer to `sc`.
- **Run counter:** counts consecutive cycles at the current level of `sc`, saturating.
  - It loads 1 on the first cycle of a new level.
  - L is the run length: the number of cycles `sc` stayed at that level.
- **States:**
  - **IDLE:** wait for QUIET consecutive `sc`=0 cycles, then go to ARMED. If `sc`=1 arrives first, the quiet count restarts and the state stays IDLE.
  - **ARMED:** the first `sc`=1 goes to REF.
  - **REF:** measures the start bar. On its falling edge, N = L.
    - N < MIN_N or N > 2^(CNT_W-2)-1 gives `err` and a return to IDLE.
    - Otherwise go to GAP, with bit count = 0 and symbol index k = 0.
  - **GAP:** a space. If the space reaches QUIET, go to ERR_Q. A rising `sc` goes to BAR.
  - **BAR:** the bar is classified on its falling edge, and the bit is shifted in MSB-first:
    - L < N>>1: too short, giving `err` and a return to IDLE.
    - L < N+(N>>1): narrow, bit = 0.
    - L ≥ N+(N>>1): wide, bit = 1.
    - L > 4N: `err` is raised the cycle the counter exceeds 4N, without waiting for the bar to end, and the state returns to IDLE.
  - **After the 5th bit of a symbol:** drive `I` = the 5-bit word and `PG` = one-hot(4-k), then k increments. If k was 4, go to DONE; else go to GAP.
  - **DONE:** QUIET zeros give a `code_done` pulse, then ARMED. A bar arriving before quiet gives `err`, then IDLE.
  - **ERR_Q:** a quiet zone arrived mid-code (fewer than 5 symbols, or a partial symbol). Raise `err` and go to ARMED, since the quiet zone is already satisfied.
- Spaces are not classified; only their quiet timeout matters.
- **Reset:** clears the synchroniser and counters, sets `I`=0, `PG`=0, `err`=0, `code_done`=0, and enters IDLE with the quiet count at 0. This holds both from power-up and mid-code.

## Timing
- Latency from a `scan` edge to the `sc` edge is 2 clocks.
- `I`/`PG` update on the same clock edge that first samples `sc`=0 after the 5th bar. They are held for exactly 1 cycle, then return to 0.
- `err` and `code_done` are 1-cycle pulses, registered. They are never asserted in the same cycle as `PG` != 0.
- Five consecutive symbols pulse PG = 16, 8, 4, 2, 1.
- Each space between bars must be at least 1 cycle.
- The counter saturates; it never wraps.

## Test plan
All scenarios use QUIET=8, MIN_N=2, N=4, so narrow = 4 cycles and wide = 8 cycles.
- **Reset then a valid code:** `reset`=1 for 2 cycles. Then 8 zeros, start bar 4, space 4, then five symbols, the first being bars W,W,W,W,N (spaces 4), then 8 zeros.
  - Required: `I`=30 with `PG`=16 for 1 cycle.
  - Then PG=8, 4, 2, 1 with their matching I values.
  - Then `code_done` pulses 8 cycles after the last bar falls.
- **Threshold boundary:** with N=4, a bar of 5 cycles decodes as 0 and a bar of 6 cycles decodes as 1. Check with symbol bars 5,6,5,6,5, which must give I=01010=10.
- **Short and long bars:**
  - A 1-cycle bar gives `err`, with no PG.
  - A 17-cycle bar gives `err` on the cycle the counter reaches 17, before `sc` falls.
- **Mid-code quiet:** 2 symbols, then 8 zeros. Required: `err` pulse, PG never reaches 4, and the next start bar is accepted without a new quiet zone.
- **Reset mid-symbol:** assert `reset` after 3 bars of symbol 0. Required: outputs are 0 the next cycle, and a code restarted after a quiet zone decodes correctly.
- **Start bar too small:** N=1 gives `err` and IDLE. A subsequent code is ignored until 8 quiet cycles have been seen.
